// File: rtl/imem_loader.sv
// Boot loader: byte stream -> little-endian words -> instruction memory writes.
// Holds the CPU in reset until the final word has landed.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_LAST, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  logic [31:0] r_count;
  logic [31:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_buf;
  logic        r_ready;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_hold;
  logic        r_done;
  logic        r_err;

  logic        w_acc;
  logic [31:0] w_len;
  logic [31:0] w_word;
  logic        w_last;

  assign w_acc  = rx_valid && r_ready;
  assign w_len  = {rx_data, r_count[31:8]};
  assign w_word = {rx_data, r_buf};
  assign w_last = (r_word_idx == r_count - 32'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_buf      <= '0;
      r_ready    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_hold     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state    <= S_LEN;
            r_ready    <= 1'b1;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_byte_idx <= '0;
            r_count    <= '0;
          end
        end
        S_LEN: begin
          if (w_acc) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            r_count    <= w_len;
            if (r_byte_idx == 2'd3) begin
              if (w_len == 32'd0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_hold  <= 1'b0;
                r_ready <= 1'b0;
              end else if (w_len > MAX_WORDS) begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
                r_ready <= 1'b0;
              end else begin
                r_state    <= S_DATA;
                r_word_idx <= '0;
              end
            end
          end
        end
        S_DATA: begin
          if (w_acc) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            r_buf      <= {rx_data, r_buf[23:8]};
            if (r_byte_idx == 2'd3) begin
              r_wdata    <= w_word;
              r_addr     <= BASE_ADDR + {r_word_idx[29:0], 2'b00};
              r_we       <= 1'b1;
              r_word_idx <= r_word_idx + 32'd1;
              // Final word: stop taking bytes, release CPU after the write.
              if (w_last) begin
                r_state <= S_LAST;
                r_ready <= 1'b0;
              end
            end
          end
        end
        S_LAST: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_hold  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_ready   = r_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign done       = r_done;
  assign err        = r_err;

endmodule
